// File: rtl/cotm32_csr_file.sv
// ---------------------------------------------------------------------------
// cotm32_csr_file
//
// Machine-mode CSR file and trap controller for the cotm32 core. It sits
// beside the execute stage, executes Zicsr read/modify/write operations,
// records trap state on exception/interrupt entry, restores it on mret,
// produces the trap target PC (direct or vectored), raises machine
// timer/external interrupt requests and runs the 64-bit mcycle/minstret
// counters.
//
// Ports:
//   clk          clock, all state updates on the rising edge
//   rst          synchronous active-high reset
//   csr_op       Zicsr operation (NONE/RW/RS/RC)
//   csr_addr     12-bit CSR address
//   csr_wdata    operand (rs1 or zero-extended uimm)
//   csr_rdata    current value of the addressed CSR (combinational)
//   csr_illegal  access is illegal this cycle (combinational)
//   trap_valid   take a trap this cycle
//   trap_cause   mcause value for the trap (MSB = interrupt)
//   trap_pc      PC saved into mepc
//   trap_tval    value saved into mtval
//   mret         mret retiring this cycle
//   inst_retire  one instruction retired this cycle
//   irq_timer    machine timer interrupt line (level)
//   irq_ext      machine external interrupt line (level)
//   irq_pending  enabled interrupt pending and mstatus.MIE set
//   irq_cause    mcause value for the pending interrupt
//   trap_target  PC to fetch on trap entry (combinational)
//   mepc_out     current mepc, the mret return address
// ---------------------------------------------------------------------------
module cotm32_csr_file #(
  parameter int unsigned      MXLEN       = 32,
  parameter logic [MXLEN-1:0] MTVEC_RESET = '0,
  parameter bit               VECTORED_EN = 1'b1,
  parameter bit               COUNTER_EN  = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       csr_op,
  input  logic [11:0]      csr_addr,
  input  logic [MXLEN-1:0] csr_wdata,
  output logic [MXLEN-1:0] csr_rdata,
  output logic             csr_illegal,
  input  logic             trap_valid,
  input  logic [MXLEN-1:0] trap_cause,
  input  logic [MXLEN-1:0] trap_pc,
  input  logic [MXLEN-1:0] trap_tval,
  input  logic             mret,
  input  logic             inst_retire,
  input  logic             irq_timer,
  input  logic             irq_ext,
  output logic             irq_pending,
  output logic [MXLEN-1:0] irq_cause,
  output logic [MXLEN-1:0] trap_target,
  output logic [MXLEN-1:0] mepc_out
);

  localparam int unsigned CW = 2 * MXLEN;

  typedef enum logic [1:0] {
    CSR_NONE = 2'b00,
    CSR_RW   = 2'b01,
    CSR_RS   = 2'b10,
    CSR_RC   = 2'b11
  } csrOp_e;

  localparam logic [11:0] ADDR_MSTATUS   = 12'h300;
  localparam logic [11:0] ADDR_MIE       = 12'h304;
  localparam logic [11:0] ADDR_MTVEC     = 12'h305;
  localparam logic [11:0] ADDR_MSCRATCH  = 12'h340;
  localparam logic [11:0] ADDR_MEPC      = 12'h341;
  localparam logic [11:0] ADDR_MCAUSE    = 12'h342;
  localparam logic [11:0] ADDR_MTVAL     = 12'h343;
  localparam logic [11:0] ADDR_MIP       = 12'h344;
  localparam logic [11:0] ADDR_MCYCLE    = 12'hB00;
  localparam logic [11:0] ADDR_MCYCLEH   = 12'hB80;
  localparam logic [11:0] ADDR_MINSTRET  = 12'hB02;
  localparam logic [11:0] ADDR_MINSTRETH = 12'hB82;

  // Clears the two low bits: mepc and the mtvec base are word aligned.
  localparam logic [MXLEN-1:0] ALIGN_MASK = {{(MXLEN-2){1'b1}}, 2'b00};
  // mtvec bit1 is always 0; bit0 (vectored mode) only survives when allowed.
  localparam logic [MXLEN-1:0] MTVEC_MASK =
    VECTORED_EN ? {{(MXLEN-2){1'b1}}, 2'b01} : ALIGN_MASK;

  // Architectural state. Only the writable bits of mstatus and mie exist.
  logic             mstatusMie_q, mstatusMie_d;
  logic             mstatusMpie_q, mstatusMpie_d;
  logic             mieMtie_q, mieMtie_d;
  logic             mieMeie_q, mieMeie_d;
  logic [MXLEN-1:0] mtvec_q, mtvec_d;
  logic [MXLEN-1:0] mscratch_q, mscratch_d;
  logic [MXLEN-1:0] mepc_q, mepc_d;
  logic [MXLEN-1:0] mcause_q, mcause_d;
  logic [MXLEN-1:0] mtval_q, mtval_d;
  logic [CW-1:0]    mcycle_q, mcycle_d;
  logic [CW-1:0]    minstret_q, minstret_d;

  csrOp_e           op;
  logic [MXLEN-1:0] mstatusRead;
  logic [MXLEN-1:0] mieRead;
  logic [MXLEN-1:0] mipRead;
  logic [MXLEN-1:0] csrOld;
  logic [MXLEN-1:0] csrNew;
  logic             csrImpl;
  logic             csrIsMip;
  logic             csrIsCounter;
  logic             writeReq;
  logic             csrWe;
  logic             extEn;
  logic             timEn;
  logic [MXLEN-1:0] tvecBase;
  logic [MXLEN-1:0] vecOffset;

  assign op = csrOp_e'(csr_op);

  // Rebuild the architectural views of the sparse registers: mstatus reports
  // MPP as machine mode permanently, and mip mirrors the interrupt lines.
  always_comb begin
    mstatusRead        = '0;
    mstatusRead[3]     = mstatusMie_q;
    mstatusRead[7]     = mstatusMpie_q;
    mstatusRead[12:11] = 2'b11;
    mieRead            = '0;
    mieRead[7]         = mieMtie_q;
    mieRead[11]        = mieMeie_q;
    mipRead            = '0;
    mipRead[7]         = irq_timer;
    mipRead[11]        = irq_ext;
  end

  // Address decode and read mux. Unimplemented addresses read as zero and
  // are flagged so the access can be rejected; counters count as
  // unimplemented when they are compiled out.
  always_comb begin
    csrImpl      = 1'b1;
    csrIsMip     = 1'b0;
    csrIsCounter = 1'b0;
    csrOld       = '0;
    case (csr_addr)
      ADDR_MSTATUS:  csrOld = mstatusRead;
      ADDR_MIE:      csrOld = mieRead;
      ADDR_MTVEC:    csrOld = mtvec_q;
      ADDR_MSCRATCH: csrOld = mscratch_q;
      ADDR_MEPC:     csrOld = mepc_q;
      ADDR_MCAUSE:   csrOld = mcause_q;
      ADDR_MTVAL:    csrOld = mtval_q;
      ADDR_MIP: begin
        csrIsMip = 1'b1;
        csrOld   = mipRead;
      end
      ADDR_MCYCLE: begin
        csrIsCounter = 1'b1;
        csrOld       = mcycle_q[MXLEN-1:0];
      end
      ADDR_MCYCLEH: begin
        csrIsCounter = 1'b1;
        csrOld       = mcycle_q[CW-1:MXLEN];
      end
      ADDR_MINSTRET: begin
        csrIsCounter = 1'b1;
        csrOld       = minstret_q[MXLEN-1:0];
      end
      ADDR_MINSTRETH: begin
        csrIsCounter = 1'b1;
        csrOld       = minstret_q[CW-1:MXLEN];
      end
      default: csrImpl = 1'b0;
    endcase
    if (csrIsCounter && !COUNTER_EN) begin
      csrImpl = 1'b0;
      csrOld  = '0;
    end
  end

  // RS/RC with a zero operand is a pure read, which is what lets software
  // read mip without trapping; only real writes can be rejected for mip.
  always_comb begin
    writeReq    = (op == CSR_RW) ||
                  (((op == CSR_RS) || (op == CSR_RC)) && (csr_wdata != '0));
    csr_illegal = (op != CSR_NONE) && (!csrImpl || (csrIsMip && writeReq));
    csrWe       = writeReq && !csr_illegal && !trap_valid && !mret;
    case (op)
      CSR_RW:  csrNew = csr_wdata;
      CSR_RS:  csrNew = csrOld | csr_wdata;
      CSR_RC:  csrNew = csrOld & ~csr_wdata;
      default: csrNew = csrOld;
    endcase
  end

  assign csr_rdata = csrOld;

  // Next-state logic. Trap entry wins over mret, which wins over a CSR
  // write; the losers are simply not applied. Counters tick every cycle
  // unless software is writing that particular counter this cycle.
  always_comb begin
    mstatusMie_d  = mstatusMie_q;
    mstatusMpie_d = mstatusMpie_q;
    mieMtie_d     = mieMtie_q;
    mieMeie_d     = mieMeie_q;
    mtvec_d       = mtvec_q;
    mscratch_d    = mscratch_q;
    mepc_d        = mepc_q;
    mcause_d      = mcause_q;
    mtval_d       = mtval_q;
    mcycle_d      = mcycle_q + CW'(1);
    minstret_d    = minstret_q + CW'(inst_retire);

    if (trap_valid) begin
      mepc_d        = trap_pc & ALIGN_MASK;
      mcause_d      = trap_cause;
      mtval_d       = trap_tval;
      mstatusMpie_d = mstatusMie_q;
      mstatusMie_d  = 1'b0;
    end else if (mret) begin
      mstatusMie_d  = mstatusMpie_q;
      mstatusMpie_d = 1'b1;
    end else if (csrWe) begin
      case (csr_addr)
        ADDR_MSTATUS: begin
          mstatusMie_d  = csrNew[3];
          mstatusMpie_d = csrNew[7];
        end
        ADDR_MIE: begin
          mieMtie_d = csrNew[7];
          mieMeie_d = csrNew[11];
        end
        ADDR_MTVEC:     mtvec_d    = csrNew & MTVEC_MASK;
        ADDR_MSCRATCH:  mscratch_d = csrNew;
        ADDR_MEPC:      mepc_d     = csrNew & ALIGN_MASK;
        ADDR_MCAUSE:    mcause_d   = csrNew;
        ADDR_MTVAL:     mtval_d    = csrNew;
        ADDR_MCYCLE:    mcycle_d   = {mcycle_q[CW-1:MXLEN], csrNew};
        ADDR_MCYCLEH:   mcycle_d   = {csrNew, mcycle_q[MXLEN-1:0]};
        ADDR_MINSTRET:  minstret_d = {minstret_q[CW-1:MXLEN], csrNew};
        ADDR_MINSTRETH: minstret_d = {csrNew, minstret_q[MXLEN-1:0]};
        default: ;
      endcase
    end
  end

  // State register with synchronous reset; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (rst) begin
      mstatusMie_q  <= 1'b0;
      mstatusMpie_q <= 1'b0;
      mieMtie_q     <= 1'b0;
      mieMeie_q     <= 1'b0;
      mtvec_q       <= MTVEC_RESET;
      mscratch_q    <= '0;
      mepc_q        <= '0;
      mcause_q      <= '0;
      mtval_q       <= '0;
      mcycle_q      <= '0;
      minstret_q    <= '0;
    end else begin
      mstatusMie_q  <= mstatusMie_d;
      mstatusMpie_q <= mstatusMpie_d;
      mieMtie_q     <= mieMtie_d;
      mieMeie_q     <= mieMeie_d;
      mtvec_q       <= mtvec_d;
      mscratch_q    <= mscratch_d;
      mepc_q        <= mepc_d;
      mcause_q      <= mcause_d;
      mtval_q       <= mtval_d;
      mcycle_q      <= mcycle_d;
      minstret_q    <= minstret_d;
    end
  end

  // Interrupt request: external has priority over timer.
  always_comb begin
    extEn       = mieMeie_q & irq_ext;
    timEn       = mieMtie_q & irq_timer;
    irq_pending = mstatusMie_q & (extEn | timEn);
    irq_cause   = extEn ? {1'b1, (MXLEN-1)'(11)} : {1'b1, (MXLEN-1)'(7)};
  end

  // Trap target: vectored only for interrupts in vectored mode, where each
  // cause gets its own word-sized slot above the base.
  always_comb begin
    tvecBase  = mtvec_q & ALIGN_MASK;
    vecOffset = {trap_cause[MXLEN-3:0], 2'b00};
    if (mtvec_q[0] && trap_cause[MXLEN-1]) begin
      trap_target = tvecBase + vecOffset;
    end else begin
      trap_target = tvecBase;
    end
  end

  assign mepc_out = mepc_q;

endmodule

// File: tb/tb_cotm32_csr_file.sv
// ---------------------------------------------------------------------------
// tb_cotm32_csr_file
//
// Self-checking bench for cotm32_csr_file. Each cycle the stimulus process
// drives the inputs, predicts every combinational output from a behavioural
// model of the CSR file and pushes that prediction into a scoreboard queue;
// a monitor pops and compares on the falling edge. Directed scenarios are
// followed by a long randomised run.
// ---------------------------------------------------------------------------
module tb_cotm32_csr_file;

  localparam logic [31:0] TB_MTVEC_RESET = 32'h0000_0100;

  localparam logic [1:0] OP_NONE = 2'd0;
  localparam logic [1:0] OP_RW   = 2'd1;
  localparam logic [1:0] OP_RS   = 2'd2;
  localparam logic [1:0] OP_RC   = 2'd3;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  csr_op;
  logic [11:0] csr_addr;
  logic [31:0] csr_wdata;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        trap_valid;
  logic [31:0] trap_cause;
  logic [31:0] trap_pc;
  logic [31:0] trap_tval;
  logic        mret;
  logic        inst_retire;
  logic        irq_timer;
  logic        irq_ext;
  logic        irq_pending;
  logic [31:0] irq_cause;
  logic [31:0] trap_target;
  logic [31:0] mepc_out;

  cotm32_csr_file #(
    .MXLEN      (32),
    .MTVEC_RESET(TB_MTVEC_RESET),
    .VECTORED_EN(1'b1),
    .COUNTER_EN (1'b1)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .csr_op     (csr_op),
    .csr_addr   (csr_addr),
    .csr_wdata  (csr_wdata),
    .csr_rdata  (csr_rdata),
    .csr_illegal(csr_illegal),
    .trap_valid (trap_valid),
    .trap_cause (trap_cause),
    .trap_pc    (trap_pc),
    .trap_tval  (trap_tval),
    .mret       (mret),
    .inst_retire(inst_retire),
    .irq_timer  (irq_timer),
    .irq_ext    (irq_ext),
    .irq_pending(irq_pending),
    .irq_cause  (irq_cause),
    .trap_target(trap_target),
    .mepc_out   (mepc_out)
  );

  // Free-running clock, rising edges at 5, 15, 25, ...
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    bit          checkRdata;
    bit          illegal;
    bit          pending;
    logic [31:0] cause;
    logic [31:0] target;
    logic [31:0] mepc;
  } expect_t;

  expect_t expQ[$];
  expect_t monExp;
  int      checks   = 0;
  int      failures = 0;

  // Behavioural model of the architectural state.
  bit          mMie;
  bit          mMpie;
  logic [31:0] mMieReg;
  logic [31:0] mMtvec;
  logic [31:0] mMscratch;
  logic [31:0] mMepc;
  logic [31:0] mMcause;
  logic [31:0] mMtval;
  logic [63:0] mCycle;
  logic [63:0] mInstret;

  logic [11:0] addrList [17] = '{
    12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
    12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82,
    12'h301, 12'h000, 12'hC00, 12'h7C0, 12'h3FF
  };

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual,
               expected, $time);
    end
  endtask

  function automatic bit modelImpl(input logic [11:0] a);
    case (a)
      12'h300, 12'h304, 12'h305, 12'h340, 12'h341, 12'h342, 12'h343,
      12'h344, 12'hB00, 12'hB80, 12'hB02, 12'hB82: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] modelRead(input logic [11:0] a);
    case (a)
      12'h300: return 32'h0000_1800 | (32'(mMie) << 3) | (32'(mMpie) << 7);
      12'h304: return mMieReg;
      12'h305: return mMtvec;
      12'h340: return mMscratch;
      12'h341: return mMepc;
      12'h342: return mMcause;
      12'h343: return mMtval;
      12'h344: return (32'(irq_timer) << 7) | (32'(irq_ext) << 11);
      12'hB00: return mCycle[31:0];
      12'hB80: return mCycle[63:32];
      12'hB02: return mInstret[31:0];
      12'hB82: return mInstret[63:32];
      default: return 32'h0;
    endcase
  endfunction

  function automatic bit modelIsWrite(input logic [1:0] o, input logic [31:0] w);
    return (o == OP_RW) || ((o == OP_RS || o == OP_RC) && w != 32'h0);
  endfunction

  function automatic bit modelIllegal(input logic [1:0] o, input logic [11:0] a,
                                      input logic [31:0] w);
    if (o == OP_NONE) return 1'b0;
    if (!modelImpl(a)) return 1'b0 == 1'b0;
    return (a == 12'h344) && modelIsWrite(o, w);
  endfunction

  // Advance the model by one rising edge using the inputs that were held
  // across that edge.
  task automatic modelStep();
    logic [31:0] oldV;
    logic [31:0] newV;
    bit          cycW;
    bit          insW;
    cycW = 1'b0;
    insW = 1'b0;
    if (rst) begin
      mMie = 0; mMpie = 0; mMieReg = 0; mMtvec = TB_MTVEC_RESET;
      mMscratch = 0; mMepc = 0; mMcause = 0; mMtval = 0;
      mCycle = 0; mInstret = 0;
    end else begin
      if (trap_valid) begin
        mMepc   = {trap_pc[31:2], 2'b00};
        mMcause = trap_cause;
        mMtval  = trap_tval;
        mMpie   = mMie;
        mMie    = 1'b0;
      end else if (mret) begin
        mMie  = mMpie;
        mMpie = 1'b1;
      end else if (modelIsWrite(csr_op, csr_wdata) &&
                   !modelIllegal(csr_op, csr_addr, csr_wdata)) begin
        oldV = modelRead(csr_addr);
        if (csr_op == OP_RW)      newV = csr_wdata;
        else if (csr_op == OP_RS) newV = oldV | csr_wdata;
        else                      newV = oldV & ~csr_wdata;
        case (csr_addr)
          12'h300: begin mMie = newV[3]; mMpie = newV[7]; end
          12'h304: mMieReg   = newV & 32'h0000_0880;
          12'h305: mMtvec    = newV & 32'hFFFF_FFFD;
          12'h340: mMscratch = newV;
          12'h341: mMepc     = newV & 32'hFFFF_FFFC;
          12'h342: mMcause   = newV;
          12'h343: mMtval    = newV;
          12'hB00: begin mCycle[31:0]    = newV; cycW = 1'b1; end
          12'hB80: begin mCycle[63:32]   = newV; cycW = 1'b1; end
          12'hB02: begin mInstret[31:0]  = newV; insW = 1'b1; end
          12'hB82: begin mInstret[63:32] = newV; insW = 1'b1; end
          default: ;
        endcase
      end
      if (!cycW) mCycle = mCycle + 64'd1;
      if (!insW && inst_retire) mInstret = mInstret + 64'd1;
    end
  endtask

  task automatic clearInputs();
    rst         = 1'b0;
    csr_op      = OP_NONE;
    csr_addr    = 12'h0;
    csr_wdata   = 32'h0;
    trap_valid  = 1'b0;
    trap_cause  = 32'h0;
    trap_pc     = 32'h0;
    trap_tval   = 32'h0;
    mret        = 1'b0;
    inst_retire = 1'b0;
    irq_timer   = 1'b0;
    irq_ext     = 1'b0;
  endtask

  // Drive the CSR port and push the predicted combinational outputs.
  task automatic applyStimulus(input logic [1:0] o, input logic [11:0] a,
                               input logic [31:0] w);
    expect_t e;
    logic [31:0] base;
    csr_op    = o;
    csr_addr  = a;
    csr_wdata = w;
    base = {mMtvec[31:2], 2'b00};
    e.rdata      = modelRead(a);
    e.checkRdata = modelImpl(a);
    e.illegal    = modelIllegal(o, a, w);
    e.pending    = mMie && ((mMieReg[11] && irq_ext) || (mMieReg[7] && irq_timer));
    e.cause      = (mMieReg[11] && irq_ext) ? 32'h8000_000B : 32'h8000_0007;
    if (mMtvec[0] && trap_cause[31])
      e.target = base + 32'd4 * {1'b0, trap_cause[30:0]};
    else
      e.target = base;
    e.mepc = mMepc;
    expQ.push_back(e);
  endtask

  task automatic stepCycle();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  // Scoreboard monitor: compare the oldest prediction on the falling edge.
  always @(negedge clk) begin
    if (expQ.size() > 0) begin
      monExp = expQ.pop_front();
      if (monExp.checkRdata) checkOutput("csr_rdata", csr_rdata, monExp.rdata);
      checkOutput("csr_illegal", 32'(csr_illegal), 32'(monExp.illegal));
      checkOutput("irq_pending", 32'(irq_pending), 32'(monExp.pending));
      checkOutput("irq_cause", irq_cause, monExp.cause);
      checkOutput("trap_target", trap_target, monExp.target);
      checkOutput("mepc_out", mepc_out, monExp.mepc);
    end
  end

  initial begin
    clearInputs();
    rst = 1'b1;
    repeat (2) begin
      @(posedge clk);
      modelStep();
    end
    #1;
    rst = 1'b0;

    // Reset values.
    applyStimulus(OP_NONE, 12'h305, 32'h0);
    #2 checkOutput("mtvec reset", csr_rdata, TB_MTVEC_RESET);
    checkOutput("irq_pending reset", 32'(irq_pending), 32'h0);
    checkOutput("csr_illegal reset", 32'(csr_illegal), 32'h0);
    stepCycle();
    applyStimulus(OP_NONE, 12'h300, 32'h0);
    #2 checkOutput("mstatus reset", csr_rdata, 32'h0000_1800);
    stepCycle();
    applyStimulus(OP_NONE, 12'h342, 32'h0);
    #2 checkOutput("mcause reset", csr_rdata, 32'h0);
    stepCycle();

    // mscratch RW / RS / RC.
    applyStimulus(OP_RW, 12'h340, 32'hDEAD_BEEF);
    stepCycle();
    applyStimulus(OP_RS, 12'h340, 32'h0000_000F);
    #2 checkOutput("mscratch after rw", csr_rdata, 32'hDEAD_BEEF);
    stepCycle();
    applyStimulus(OP_RC, 12'h340, 32'h0000_00F0);
    #2 checkOutput("mscratch after rs", csr_rdata, 32'hDEAD_BEEF);
    stepCycle();
    applyStimulus(OP_NONE, 12'h340, 32'h0);
    #2 checkOutput("mscratch after rc", csr_rdata, 32'hDEAD_BE0F);
    stepCycle();

    // Vectored trap target.
    applyStimulus(OP_RW, 12'h305, 32'h0000_1001);
    stepCycle();
    trap_valid = 1'b1; trap_cause = 32'h8000_0007; trap_pc = 32'h0000_2000;
    applyStimulus(OP_NONE, 12'h305, 32'h0);
    #2 checkOutput("trap_target vectored", trap_target, 32'h0000_101C);
    stepCycle();
    clearInputs();
    trap_valid = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h0000_2004;
    applyStimulus(OP_NONE, 12'h305, 32'h0);
    #2 checkOutput("trap_target exception", trap_target, 32'h0000_1000);
    stepCycle();
    clearInputs();

    // Trap entry and mret stack.
    applyStimulus(OP_RS, 12'h300, 32'h0000_0008);
    stepCycle();
    trap_valid = 1'b1; trap_cause = 32'h0000_0002; trap_pc = 32'h8000_0102;
    applyStimulus(OP_NONE, 12'h341, 32'h0);
    stepCycle();
    clearInputs();
    applyStimulus(OP_NONE, 12'h341, 32'h0);
    #2 checkOutput("mepc after trap", csr_rdata, 32'h8000_0100);
    checkOutput("mepc_out after trap", mepc_out, 32'h8000_0100);
    stepCycle();
    applyStimulus(OP_NONE, 12'h300, 32'h0);
    #2 checkOutput("mstatus after trap", csr_rdata, 32'h0000_1880);
    stepCycle();
    mret = 1'b1;
    applyStimulus(OP_NONE, 12'h300, 32'h0);
    stepCycle();
    clearInputs();
    applyStimulus(OP_NONE, 12'h300, 32'h0);
    #2 checkOutput("mstatus after mret", csr_rdata, 32'h0000_1888);
    stepCycle();

    // Interrupt priority and masking.
    applyStimulus(OP_RW, 12'h304, 32'h0000_0880);
    stepCycle();
    irq_timer = 1'b1; irq_ext = 1'b1;
    applyStimulus(OP_NONE, 12'h344, 32'h0);
    #2 checkOutput("irq_pending both", 32'(irq_pending), 32'h1);
    checkOutput("irq_cause both", irq_cause, 32'h8000_000B);
    stepCycle();
    clearInputs();
    irq_timer = 1'b1;
    applyStimulus(OP_RC, 12'h304, 32'h0000_0880);
    #2 checkOutput("irq_cause timer", irq_cause, 32'h8000_0007);
    stepCycle();
    clearInputs();
    irq_timer = 1'b1; irq_ext = 1'b1;
    applyStimulus(OP_NONE, 12'h304, 32'h0);
    #2 checkOutput("irq_pending masked", 32'(irq_pending), 32'h0);
    stepCycle();
    clearInputs();

    // mcycle carry into the high half.
    applyStimulus(OP_RW, 12'hB00, 32'hFFFF_FFFF);
    stepCycle();
    applyStimulus(OP_RW, 12'hB80, 32'h0);
    stepCycle();
    applyStimulus(OP_NONE, 12'hB80, 32'h0);
    stepCycle();
    applyStimulus(OP_NONE, 12'hB80, 32'h0);
    #2 checkOutput("mcycleh carry", csr_rdata, 32'h1);
    stepCycle();

    // Illegal write to mip.
    irq_timer = 1'b1;
    applyStimulus(OP_RW, 12'h344, 32'h0000_0880);
    #2 checkOutput("mip rw illegal", 32'(csr_illegal), 32'h1);
    stepCycle();
    clearInputs();

    // Trap beats a CSR write to mepc.
    trap_valid = 1'b1; trap_cause = 32'h0000_0005; trap_pc = 32'h4000_0006;
    applyStimulus(OP_RW, 12'h341, 32'h0000_1234);
    stepCycle();
    clearInputs();
    applyStimulus(OP_NONE, 12'h341, 32'h0);
    #2 checkOutput("mepc trap wins", csr_rdata, 32'h4000_0004);
    stepCycle();

    // Randomised run against the model.
    for (int i = 0; i < 3000; i++) begin
      clearInputs();
      rst         = ($urandom_range(0, 299) == 0);
      trap_valid  = ($urandom_range(0, 19) == 0);
      trap_cause  = ($urandom_range(0, 7) == 0) ? $urandom() :
                    {1'($urandom_range(0, 1)), 31'($urandom_range(0, 40))};
      trap_pc     = $urandom();
      trap_tval   = $urandom();
      mret        = ($urandom_range(0, 14) == 0);
      inst_retire = 1'($urandom_range(0, 1));
      irq_timer   = 1'($urandom_range(0, 1));
      irq_ext     = 1'($urandom_range(0, 1));
      applyStimulus(2'($urandom_range(0, 3)),
                    addrList[$urandom_range(0, 16)],
                    ($urandom_range(0, 4) == 0) ? 32'h0 :
                    ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFFF : $urandom());
      stepCycle();
    end

    clearInputs();
    repeat (2) @(negedge clk);
    #1 checkOutput("scoreboard drained", 32'(expQ.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
